// File: rtl/fixdiv_pkg.sv
// fixdiv_pkg: shared state encoding and latency helper for the iterative fixed-point divider.
package fixdiv_pkg;
  typedef enum logic [1:0] {IDLE, DIV, FIN, OUT} state_t;
  function automatic int latency(input int w, input int frac);
    return w + frac + 1;
  endfunction
endpackage

// File: rtl/fixdiv_iter_if.sv
// fixdiv_iter_if: operand/result handshake bundle; i_/o_ names are seen from the divider side.
interface fixdiv_iter_if #(parameter int W = 32);
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_quotient;
  logic         o_ovf;
  logic         o_dbz;
  modport slave (input i_valid, i_dividend, i_divisor, i_ready,
                 output o_ready, o_valid, o_quotient, o_ovf, o_dbz);
  modport master (output i_valid, i_dividend, i_divisor, i_ready,
                  input o_ready, o_valid, o_quotient, o_ovf, o_dbz);
endinterface

// File: rtl/fixdiv_round_sat.sv
// fixdiv_round_sat: optional round-half-away, sign application and saturation of the raw magnitude.
module fixdiv_round_sat #(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int ROUND = 0
) (
  input  logic [W+FRAC-1:0] i_q,
  input  logic [W-1:0]      i_r,
  input  logic [W:0]        i_b,
  input  logic              i_sign,
  input  logic              i_dbz,
  output logic [W-1:0]      o_quotient,
  output logic              o_ovf
);
  localparam int N = W + FRAC;
  logic [N:0]   w_qr;
  logic [N:0]   w_lim;
  logic         w_sat;
  logic [W-1:0] w_signed;
  logic [W-1:0] w_rail;
  always_comb begin
    w_qr       = {1'b0, i_q} + (N+1)'((ROUND != 0) && ({i_r, 1'b0} >= i_b));
    // Negative results may reach one step further than positive ones.
    w_lim      = ((N+1)'(1) << (W-1)) - (N+1)'(!i_sign);
    w_sat      = w_qr > w_lim;
    w_signed   = i_sign ? -w_qr[W-1:0] : w_qr[W-1:0];
    w_rail     = i_sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    o_quotient = (i_dbz || w_sat) ? w_rail : w_signed;
    o_ovf      = w_sat && !i_dbz;
  end
endmodule

// File: rtl/fixdiv_iter.sv
// fixdiv_iter: signed Q-format divider, one restoring shift-subtract step per cycle,
// fixed latency W+FRAC+1 from accept to o_valid.
module fixdiv_iter import fixdiv_pkg::*; #(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int ROUND = 0
) (
  input logic           i_clk,
  input logic           i_rst_n,
  fixdiv_iter_if.slave  bus
);
  localparam int N  = W + FRAC;
  localparam int CW = $clog2(N);
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_sign, r_dbz;
  logic [W:0]    r_b;
  logic [W-1:0]  r_rem;
  logic [N-1:0]  r_q;
  logic          r_valid, r_ovf, r_odbz;
  logic [W-1:0]  r_quot;
  logic [W:0]    w_abs_a, w_abs_b, w_trial;
  logic          w_ge;
  logic [W-1:0]  w_rem_nxt, w_quot;
  logic          w_ovf;
  always_comb begin
    w_abs_a   = bus.i_dividend[W-1] ? -{1'b1, bus.i_dividend} : {1'b0, bus.i_dividend};
    w_abs_b   = bus.i_divisor[W-1] ? -{1'b1, bus.i_divisor} : {1'b0, bus.i_divisor};
    w_trial   = {r_rem, r_q[N-1]};
    w_ge      = w_trial >= r_b;
    w_rem_nxt = w_ge ? W'(w_trial - r_b) : w_trial[W-1:0];
    w_next    = r_state;
    w_next    = (r_state == IDLE && bus.i_valid) ? DIV :
                (r_state == DIV && r_cnt == CW'(N-1)) ? FIN :
                (r_state == FIN) ? OUT :
                (r_state == OUT && bus.i_ready) ? IDLE : r_state;
  end
  fixdiv_round_sat #(.W(W), .FRAC(FRAC), .ROUND(ROUND)) u_round_sat (
    .i_q(r_q), .i_r(r_rem), .i_b(r_b), .i_sign(r_sign), .i_dbz(r_dbz),
    .o_quotient(w_quot), .o_ovf(w_ovf)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_dbz   <= 1'b0;
      r_b     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_odbz  <= 1'b0;
      r_quot  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.i_valid) begin
        r_sign <= bus.i_dividend[W-1] ^ bus.i_divisor[W-1];
        r_dbz  <= bus.i_divisor == '0;
        r_b    <= w_abs_b;
        r_q    <= N'(w_abs_a) << FRAC;
        r_rem  <= '0;
        r_cnt  <= '0;
      end
      if (r_state == DIV) begin
        r_q   <= {r_q[N-2:0], w_ge};
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == FIN) begin
        r_valid <= 1'b1;
        r_quot  <= w_quot;
        r_ovf   <= w_ovf;
        r_odbz  <= r_dbz;
      end
      if (r_state == OUT && bus.i_ready) r_valid <= 1'b0;
    end
  end
  assign bus.o_ready    = r_state == IDLE;
  assign bus.o_valid    = r_valid;
  assign bus.o_quotient = r_quot;
  assign bus.o_ovf      = r_ovf;
  assign bus.o_dbz      = r_odbz;
endmodule

// File: doc/fixdiv_iter.md
FIXDIV_ITER -- requirements
Module: fixdiv_iter

Interface
REQ-001 SHALL have parameter W, default 32: operand and result width, in bits (two's complement).
REQ-002 SHALL have parameter FRAC, default 16: fractional bits of the Q(W-FRAC).FRAC format; legal range 0..W-1.
REQ-003 SHALL have parameter ROUND, default 0: 0 = truncate toward zero; 1 = round half away from zero.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_valid, input, 1 bit: dividend and divisor are valid.
REQ-007 SHALL have port o_ready, output, 1 bit: the block can accept an operand pair.
REQ-008 SHALL have port i_dividend, input, W bits: signed dividend A.
REQ-009 SHALL have port i_divisor, input, W bits: signed divisor B.
REQ-010 SHALL have port o_valid, output, 1 bit: result is valid.
REQ-011 SHALL have port i_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port o_quotient, output, W bits: signed A/B in Q format.
REQ-013 SHALL have port o_ovf, output, 1 bit: the result saturated because of overflow.
REQ-014 SHALL have port o_dbz, output, 1 bit: divide by zero.

Function
REQ-015 SHALL use states IDLE, DIV, FIN and OUT.
- IDLE -> DIV on accept.
- DIV -> FIN after N = W+FRAC iterations.
- FIN -> OUT unconditionally.
- OUT -> IDLE on the output handshake.
REQ-016 SHALL drive o_ready high only in IDLE; accept occurs on a rising edge where i_valid and o_ready are both high.
REQ-017 SHALL, on accept, register sign = A[W-1]^B[W-1], |A| and |B| as W+1-bit magnitudes (so -2^(W-1) is exact), and clear the remainder and iteration counter.
REQ-018 SHALL perform one restoring shift-subtract step per DIV cycle on the dividend |A|<<FRAC, producing an N-bit unsigned quotient magnitude Q and a remainder R.
REQ-019 SHALL, in FIN, when ROUND=1 and 2R >= |B|, increment Q by one; the increment is computed before saturation.
REQ-020 SHALL, in FIN, compute the result as -Q or +Q by sign, with these saturation rules:
- if sign=0 and Q > 2^(W-1)-1, output 2^(W-1)-1 and set o_ovf=1;
- if sign=1 and Q > 2^(W-1), output -2^(W-1) and set o_ovf=1;
- otherwise set o_ovf=0.
REQ-021 SHALL, when B=0, set o_dbz=1 and o_ovf=0, and output 2^(W-1)-1 if A >= 0, else -2^(W-1); latency is unchanged.
REQ-022 SHALL have fixed latency: for an accept at edge t, o_valid rises after edge t+N+1.
REQ-023 SHALL hold o_valid, o_quotient, o_ovf and o_dbz stable in OUT until i_ready is high; o_valid falls on the edge that completes the handshake.
REQ-024 SHALL NOT accept new operands while busy; i_valid and operand changes during DIV, FIN and OUT are ignored.
REQ-025 SHALL give a result of 0 (o_ovf=0, o_dbz=0) when A=0 and B is nonzero.

Reset
REQ-026 SHALL, while i_rst_n is low, force the state to IDLE and clear the counter, working registers, o_quotient, o_valid, o_ovf and o_dbz, independent of i_clk.
REQ-027 SHALL, on reset asserted mid-operation, abandon the operation with no o_valid pulse; o_ready is high in the first cycle after i_rst_n deasserts.

Structure
REQ-028 SHALL place the state encoding, and a function returning the latency N+1, in the shared package fixdiv_pkg.
REQ-029 SHALL implement the FIN rounding and saturation as the sub-module fixdiv_round_sat (combinational; inputs Q, R, |B|, sign, dbz; outputs quotient, ovf).

Verification
REQ-030 SHALL cover the following directed scenarios at W=32, FRAC=16:
- 0x00030000 / 0x00020000 -> 0x00018000, ovf=0, dbz=0, o_valid exactly 49 cycles after accept.
- 0xFFFF0000 / 0x00040000 -> 0xFFFFC000; 0x80000000 / 0x00010000 -> 0x80000000, ovf=0.
- 0x00020000 / 0x00030000 -> 0x0000AAAA with ROUND=0, and 0x0000AAAB with ROUND=1.
- 0x7FFF0000 / 0x00008000 -> 0x7FFFFFFF, ovf=1; 0x80000000 / 0xFFFF0000 -> 0x7FFFFFFF, ovf=1.
- 0x00010000 / 0 -> 0x7FFFFFFF, dbz=1; 0xFFFF0000 / 0 -> 0x80000000, dbz=1.
- Back-pressure: hold i_ready low 10 cycles -> outputs stable, o_ready low; i_rst_n low mid-DIV -> no o_valid, o_ready high after release.
